iterative_div_unit: RTL
=======================

// Module: iterative_div_unit
// PURPOSE
//  Multi-cycle radix-2 restoring divider for the M-extension execute stage. Implements DIV/DIVU/REM/REMU.
//  Parametrised width; valid/ready handshake on both sides; flushable. Replaces fixed-latency IP dividers.
//  Sits beside the multiply unit; the issue logic holds the op until ready_o, and writeback drains it via ready_i.
// PARAMETERS
//  WIDTH  32  operand/result width in bits, >=4.
//  TAG_W  4   width of the opaque tag (ROB index) carried from input to output.
// PORTS
//  clk_i          in   1        clock, rising edge.
//  rst_n_i        in   1        asynchronous active-low reset.
//  clk_en_i       in   1        low: all state frozen, handshakes ignored.
//  kill_i         in   1        flush: abort any op in flight.
//  valid_i        in   1        request valid.
//  ready_o        out  1        unit can accept a request (IDLE only).
//  ops_i          in   div_ops_e  DIV_/DIVU_/REM_/REMU_.
//  dividend_i     in   WIDTH    dividend.
//  divisor_i      in   WIDTH    divisor.
//  tag_i          in   TAG_W    request tag.
//  valid_o        out  1        result valid.
//  ready_i        in   1        consumer accepts result.
//  result_o       out  WIDTH    quotient or remainder per the latched op.
//  tag_o          out  TAG_W    latched tag.
//  div_by_zero_o  out  1        divisor was zero (qualified by valid_o).
//  busy_o         out  1        state != IDLE.
// BEHAVIOUR
//  Reset: state=IDLE; ready_o=1, valid_o=0, busy_o=0, result_o/tag_o/div_by_zero_o=0.
//  FSM: IDLE -> PREP on valid_i&&ready_o&&clk_en_i. Latch op/tag; latch operands as two's-complement
//   magnitudes for DIV_/REM_. Record q_neg = sign(a)^sign(b) and r_neg = sign(a).
//   PREP: detect divisor==0 and signed overflow (a=-2^(WIDTH-1), b=-1); clear the partial remainder; load counter=WIDTH-1.
//   ITER: one restoring step per cycle, MSB first. Shift {rem,quo} left 1. If rem>=divisor, subtract and set quo[0].
//   ITER exits when counter==0, i.e. exactly WIDTH cycles in ITER.
//   FIX: apply sign correction; select quotient/remainder; register outputs -> DONE.
//   DONE: valid_o=1; outputs stable until valid_o&&ready_i, then -> IDLE (ready_o=1 next cycle).
//  Latency: valid_o rises WIDTH+3 clock edges after the accepting edge (35 at WIDTH=32); 1 op in flight max.
//  No back-to-back accept: the next request is accepted no earlier than the cycle after the result handshake.
//  Special results (RISC-V):
//   - divisor==0: quotient=all ones, remainder=dividend, div_by_zero_o=1.
//   - signed overflow: quotient=dividend, remainder=0, div_by_zero_o=0.
//  Sign rules: quotient sign = q_neg, remainder sign = dividend sign (truncating division).
//  Arithmetic: subtractor WIDTH+1 bits to hold the shifted carry; magnitude of -2^(WIDTH-1) handled unsigned.
//  kill_i: in any state, the next state is IDLE and valid_o=0 next cycle. kill_i wins over an accept in the same cycle.
//   In DONE, kill_i also wins over ready_i (result dropped).
//  clk_en_i=0: no state change, including kill_i/ready_i handling; outputs hold.
//  Async reset mid-op: immediate return to reset values; the op is lost.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: in PREP, divisor==0, signed overflow and |dividend|<|divisor| skip ITER.
//   These go PREP->FIX directly; valid_o 3 edges after accept. Results are identical to the full path.
//  Undefined: all ops take the full WIDTH+3 latency (deterministic timing).
// STRUCTURE
//  Shared package (Modules_pkg): div_ops_e (existing); new div_state_e {IDLE,PREP,ITER,FIX,DONE}.
//   Also a localparam function div_latency(width) = width+3 for issue scheduling.
//  Sub-module div_iter_step: combinational single restoring step.
//   Inputs: rem, quo, divisor. Outputs: rem_next, quo_next. WIDTH-parametrised.
//  Top: FSM, counter ($clog2(WIDTH) bits), operand/sign registers, output registers.
// TESTING (WIDTH=32, macro undefined unless stated)
//  DIV 100/7 -> 14, REM -> 2. valid_o exactly 35 edges after accept; tag_o = tag_i.
//  DIV -7/2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1).
//   DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
//  DIVU 5/0 -> 0xFFFFFFFF with div_by_zero_o=1; REM 5/0 -> 5 with flag 1.
//   DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; flag 0.
//  Backpressure: ready_i=0 for 10 cycles in DONE -> result/tag stable, ready_o=0; ready_i=1 -> IDLE next edge.
//  kill_i at ITER cycle 10 -> IDLE next edge, no valid_o. clk_en_i low 5 cycles mid-ITER -> latency +5, same result.
//   rst_n_i pulse mid-ITER -> all outputs at reset values immediately.
//  DIV_EARLY_OUT_EN: DIVU 3/10 -> 0 in 3 edges, REMU -> 3. DIVU 5/0 -> 0xFFFFFFFF in 3 edges.
//   Random compare vs reference model in both builds.

Source files
------------

// File: rtl/iterative_div_unit_pkg.sv
// Shared definitions for the iterative divider: operation and state
// encodings plus the latency helper used by issue scheduling.
package Modules_pkg;

  typedef enum logic [1:0] {
    DIV_  = 2'd0,
    DIVU_ = 2'd1,
    REM_  = 2'd2,
    REMU_ = 2'd3
  } div_ops_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  // Cycles from accept to result on the full (non-early-out) path.
  function automatic int div_latency(input int width);
    return width + 3;
  endfunction

endpackage

// File: rtl/iterative_div_unit_iter_step.sv
// One combinational radix-2 restoring step: shift {rem,quo} left by one,
// then subtract the divisor from the partial remainder if it fits.
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_next_o,
  output logic [WIDTH-1:0] quo_next_o
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  // The partial remainder is always below the divisor, so the shifted value
  // is below twice the divisor: the top bit of the difference is a pure
  // borrow and the low WIDTH bits are the new remainder when it fits.
  assign w_shifted  = {rem_i, quo_i[WIDTH-1]};
  assign w_diff     = w_shifted - {1'b0, divisor_i};
  assign w_fits     = ~w_diff[WIDTH];
  assign rem_next_o = w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign quo_next_o = {quo_i[WIDTH-2:0], w_fits};

endmodule

// File: rtl/iterative_div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU) with
// valid/ready handshakes, clock enable and flush.
// Build option: define DIV_EARLY_OUT_EN to let divide-by-zero, signed
// overflow and |dividend|<|divisor| skip the iteration phase.
module iterative_div_unit
  import Modules_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clk_en_i,
  input  logic             kill_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  div_ops_e         ops_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             div_by_zero_o,
  output logic             busy_o
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] L_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  div_ops_e         r_op;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_divisor;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dbz;
  logic             r_ovf;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_tag_o;
  logic             r_dbz_o;

  logic             w_accept;
  logic             w_in_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_dbz_det;
  logic             w_ovf_det;
  logic             w_early;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_result;

  // Operand capture: signed ops are stored as unsigned magnitudes; the
  // magnitude of the most negative value is simply its own bit pattern.
  assign w_accept    = clk_en_i && !kill_i && (r_state == IDLE) && valid_i;
  assign w_in_signed = (ops_i == DIV_) || (ops_i == REM_);
  assign w_a_neg     = w_in_signed && dividend_i[WIDTH-1];
  assign w_b_neg     = w_in_signed && divisor_i[WIDTH-1];
  assign w_a_mag     = w_a_neg ? (~dividend_i + 1'b1) : dividend_i;
  assign w_b_mag     = w_b_neg ? (~divisor_i + 1'b1) : divisor_i;

  // Signed overflow is -2^(WIDTH-1) / -1: negative dividend, negative
  // divisor (so the quotient sign is positive) and divisor magnitude one.
  assign w_dbz_det = (r_divisor == '0);
  assign w_ovf_det = r_r_neg && !r_q_neg && (r_quo == L_MIN) && (r_divisor == L_ONE);

`ifdef DIV_EARLY_OUT_EN
  logic w_small;
  assign w_small = (r_quo < r_divisor);
  assign w_early = w_dbz_det || w_ovf_det || w_small;
`else
  assign w_early = 1'b0;
`endif

  div_iter_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i      (r_rem),
    .quo_i      (r_quo),
    .divisor_i  (r_divisor),
    .rem_next_o (w_rem_next),
    .quo_next_o (w_quo_next)
  );

  // State register; a low clock enable freezes the FSM including flushes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else if (clk_en_i) begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; a flush overrides every transition.
  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    busy_o       = 1'b1;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (valid_i) w_state_next = PREP;
      end
      PREP:    w_state_next = w_early ? FIX : ITER;
      ITER:    if (r_cnt == '0) w_state_next = FIX;
      FIX:     w_state_next = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (kill_i) w_state_next = IDLE;
  end

  // Sign correction and special-case overrides for the final result.
  always_comb begin
    w_q_fix = r_q_neg ? (~r_quo + 1'b1) : r_quo;
    w_r_fix = r_r_neg ? (~r_rem + 1'b1) : r_rem;
    if (r_dbz) w_q_fix = '1;
    if (r_ovf) begin
      w_q_fix = L_MIN;
      w_r_fix = '0;
    end
    w_result = ((r_op == REM_) || (r_op == REMU_)) ? w_r_fix : w_q_fix;
  end

  // Datapath: operand latch, preparation, iteration and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt     <= '0;
      r_op      <= DIV_;
      r_tag     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_dbz     <= 1'b0;
      r_ovf     <= 1'b0;
      r_result  <= '0;
      r_tag_o   <= '0;
      r_dbz_o   <= 1'b0;
    end else if (clk_en_i && !kill_i) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op      <= ops_i;
            r_tag     <= tag_i;
            r_quo     <= w_a_mag;
            r_divisor <= w_b_mag;
            r_q_neg   <= w_a_neg ^ w_b_neg;
            r_r_neg   <= w_a_neg;
          end
        end
        PREP: begin
          r_dbz <= w_dbz_det;
          r_ovf <= w_ovf_det;
          r_cnt <= CNT_W'(WIDTH - 1);
          if (w_early) begin
            // Quotient magnitude is zero and the remainder is the dividend.
            r_rem <= r_quo;
            r_quo <= '0;
          end else begin
            r_rem <= '0;
          end
        end
        ITER: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - 1'b1;
        end
        FIX: begin
          r_result <= w_result;
          r_tag_o  <= r_tag;
          r_dbz_o  <= r_dbz;
        end
        default: ;
      endcase
    end
  end

  assign result_o      = r_result;
  assign tag_o         = r_tag_o;
  assign div_by_zero_o = r_dbz_o;

endmodule
